result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector.sv | 105 ++++++++++
 tb/tb_result_collector.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// Four-lane result collector: per-lane hold registers, round-robin arbitration into a
// first-word-fall-through output queue, with sticky per-lane overflow and a delivery counter.
module result_collector #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*DATA_W-1:0]       res_in,
    input  logic [3:0]                res_vld,
    output logic [3:0]                res_ack,
    output logic [DATA_W-1:0]         out_data,
    output logic [1:0]                out_core,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [3:0]                ovf,
    output logic [15:0]               delivered
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] hold_q [4];
    logic [3:0]        hold_full_q;
    logic [1:0]        rr_ptr_q;
    logic [DATA_W+1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [3:0]        ovf_q;
    logic [15:0]       delivered_q;

    logic [3:0] grant;
    logic [1:0] grant_lane;
    logic [1:0] lane;
    logic       push, pop;

    // Scan from the farthest offset down so the lane nearest rr_ptr wins.
    always_comb begin
        grant_lane = '0;
        push       = 1'b0;
        lane       = '0;
        if (count_q < CW'(DEPTH)) begin
            for (int i = 3; i >= 0; i--) begin
                lane = rr_ptr_q + 2'(i);
                if (hold_full_q[lane]) begin
                    grant_lane = lane;
                    push       = 1'b1;
                end
            end
        end
        grant = push ? (4'b0001 << grant_lane) : 4'b0000;
    end

    assign res_ack    = rst ? 4'b0000 : (res_vld & (~hold_full_q | grant));
    assign out_vld    = (count_q != '0);
    assign pop        = out_vld & out_rdy;
    assign out_data   = out_vld ? mem[rd_ptr_q][DATA_W-1:0] : '0;
    assign out_core   = out_vld ? mem[rd_ptr_q][DATA_W+1:DATA_W] : '0;
    assign fifo_count = count_q;
    assign ovf        = ovf_q;
    assign delivered  = delivered_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) hold_q[k] <= '0;
            hold_full_q <= '0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= '0;
            delivered_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (res_ack[k]) begin
                    hold_q[k]      <= res_in[k*DATA_W +: DATA_W];
                    hold_full_q[k] <= 1'b1;
                end else if (grant[k]) begin
                    hold_full_q[k] <= 1'b0;
                end
            end
            ovf_q <= ovf_q | (res_vld & ~res_ack);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                rr_ptr_q <= grant_lane + 2'd1;
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + PW'(1);
                delivered_q <= delivered_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage needs no reset; entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {grant_lane, hold_q[grant_lane]};
    end

endmodule

// File: tb/tb_result_collector.sv
// Randomized scoreboard bench for result_collector with a cycle-level reference model.
module tb_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] res_in;
    logic [3:0]  res_vld;
    logic [3:0]  res_ack;
    logic [7:0]  out_data;
    logic [1:0]  out_core;
    logic        out_vld;
    logic        out_rdy;
    logic [3:0]  fifo_count;
    logic [3:0]  ovf;
    logic [15:0] delivered;

    int total = 0;
    int bad   = 0;

    result_collector #(.DATA_W(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .res_in(res_in), .res_vld(res_vld), .res_ack(res_ack),
        .out_data(out_data), .out_core(out_core), .out_vld(out_vld), .out_rdy(out_rdy),
        .fifo_count(fifo_count), .ovf(ovf), .delivered(delivered)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model state
    logic [9:0] exp_q [$];
    int         m_count;
    logic [3:0] m_hf;
    logic [7:0] m_hold [4];
    int         m_rr;
    logic [3:0] m_ovf;
    int         m_deliv;
    int         g;
    logic [3:0] ack_e;
    bit         m_pop;

    task automatic model_reset();
        m_count = 0;
        m_hf    = '0;
        m_rr    = 0;
        m_ovf   = '0;
        m_deliv = 0;
        for (int k = 0; k < 4; k++) m_hold[k] = '0;
        exp_q.delete();
    endtask

    initial model_reset();

    // Model: predicts this cycle's accepts and state, then applies the coming clock edge.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            chk("ack_in_reset", {28'd0, res_ack}, 32'd0);
        end else begin
            g = -1;
            if (m_count < 8) begin
                for (int off = 0; off < 4; off++) begin
                    if (g < 0 && m_hf[(m_rr + off) % 4]) g = (m_rr + off) % 4;
                end
            end
            for (int k = 0; k < 4; k++) ack_e[k] = res_vld[k] && (!m_hf[k] || g == k);
            chk("res_ack", {28'd0, res_ack}, {28'd0, ack_e});
            chk("fifo_count", {28'd0, fifo_count}, m_count);
            chk("ovf", {28'd0, ovf}, {28'd0, m_ovf});
            chk("delivered", {16'd0, delivered}, m_deliv % 65536);
            chk("out_vld", {31'd0, out_vld}, {31'd0, m_count != 0});
            m_pop = (m_count != 0) && out_rdy;
            if (g >= 0) begin
                exp_q.push_back({2'(g), m_hold[g]});
                m_hf[g] = 1'b0;
                m_rr    = (g + 1) % 4;
            end
            for (int k = 0; k < 4; k++) begin
                if (ack_e[k]) begin
                    m_hf[k]   = 1'b1;
                    m_hold[k] = res_in[k*8 +: 8];
                end else if (res_vld[k]) begin
                    m_ovf[k] = 1'b1;
                end
            end
            m_count = m_count + (g >= 0 ? 1 : 0) - (m_pop ? 1 : 0);
            m_deliv = m_deliv + (m_pop ? 1 : 0);
        end
    end

    // Monitor: every pop the DUT performs must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_without_expected actual=%0h required=none at %0t",
                         {out_core, out_data}, $time);
            end else begin
                chk("out_entry", {22'd0, out_core, out_data}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; res_in = '0; res_vld = '0; out_rdy = 1'b0;
        step(); step();
        chk("reset_out_vld", {31'd0, out_vld}, 32'd0);
        chk("reset_out_data", {24'd0, out_data}, 32'd0);
        chk("reset_out_core", {30'd0, out_core}, 32'd0);
        rst = 1'b0;
        step();

        // Single result on lane 2: two-cycle latency
        res_in = 32'h005A_0000; res_vld = 4'b0100; out_rdy = 1'b1;
        step();
        res_vld = '0;
        chk("latency_n1_vld", {31'd0, out_vld}, 32'd0);
        step();
        chk("latency_n2_vld", {31'd0, out_vld}, 32'd1);
        chk("latency_n2_data", {24'd0, out_data}, 32'h5A);
        chk("latency_n2_core", {30'd0, out_core}, 32'd2);
        step();
        chk("single_delivered", {16'd0, delivered}, 32'd1);

        // Two simultaneous four-lane bursts
        for (int b = 0; b < 2; b++) begin
            res_in = 32'h1312_1110; res_vld = 4'b1111;
            step();
            res_vld = '0;
            repeat (7) step();
        end

        // Backpressure to full, then drain
        out_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            res_in = {24'd0, 8'(8'h20 + i)}; res_vld = 4'b0001;
            step();
        end
        res_vld = '0;
        chk("full_count", {28'd0, fifo_count}, 32'd8);
        chk("full_ovf0", {31'd0, ovf[0]}, 32'd1);
        out_rdy = 1'b1;
        repeat (12) step();

        // Randomized traffic with varying load and backpressure
        for (int i = 0; i < 1500; i++) begin
            res_in  = $urandom;
            res_vld = (i % 500 < 250) ? 4'($urandom) : 4'($urandom & $urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            step();
        end

        // Mid-stream reset: outputs clear asynchronously
        out_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            res_in = $urandom; res_vld = 4'b1111;
            step();
        end
        rst = 1'b1;
        #1;
        chk("async_out_vld", {31'd0, out_vld}, 32'd0);
        chk("async_count", {28'd0, fifo_count}, 32'd0);
        chk("async_ovf", {28'd0, ovf}, 32'd0);
        chk("async_delivered", {16'd0, delivered}, 32'd0);
        chk("async_ack", {28'd0, res_ack}, 32'd0);
        step();
        rst = 1'b0; res_vld = '0;
        step();
        res_in = 32'hC300_0000; res_vld = 4'b1000; out_rdy = 1'b1;
        step();
        res_vld = '0;
        step();
        chk("post_reset_core", {30'd0, out_core}, 32'd3);
        chk("post_reset_data", {24'd0, out_data}, 32'hC3);
        step();

        // Continuous stream of 20 values through the queue
        for (int i = 0; i < 20; i++) begin
            res_in = {24'd0, 8'(8'h40 + i)}; res_vld = 4'b0001;
            step();
        end
        res_vld = '0;
        repeat (4) step();
        chk("wrap_delivered", {16'd0, delivered}, 32'd21);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
